// File: rtl/flash_rd_ctrl_if.sv
// Client and flash-side signal bundle for flash_rd_ctrl.
// master: the read controller's view; slave: the clients' and flash device's view.
interface flash_rd_ctrl_if;
  logic        i_prg_req;
  logic [19:0] i_prg_addr;
  logic        o_prg_ack;
  logic [7:0]  o_prg_q;
  logic        i_chr_req;
  logic [19:0] i_chr_addr;
  logic        o_chr_ack;
  logic [7:0]  o_chr_q;
  logic [22:0] o_flash_addr;
  logic        o_flash_ce_n;
  logic        o_flash_oe_n;
  logic [7:0]  i_flash_q;

  modport master (
    input  i_prg_req, i_prg_addr, i_chr_req, i_chr_addr, i_flash_q,
    output o_prg_ack, o_prg_q, o_chr_ack, o_chr_q,
    output o_flash_addr, o_flash_ce_n, o_flash_oe_n
  );

  modport slave (
    output i_prg_req, i_prg_addr, i_chr_req, i_chr_addr, i_flash_q,
    input  o_prg_ack, o_prg_q, o_chr_ack, o_chr_q,
    input  o_flash_addr, o_flash_ce_n, o_flash_oe_n
  );
endinterface

// File: rtl/flash_rd_ctrl.sv
// Flash read controller: arbitrates PRG/CHR byte reads (round-robin on
// contention), runs a fixed-length flash access and returns the byte over a
// four-phase req/ack handshake. PRG maps to flash 0x000000, CHR to 0x400000.
// Optional per-port last-address read cache: define FLASH_RDCACHE_EN.
module flash_rd_ctrl #(
  parameter int WAIT_CYC = 4  // flash access time in clock cycles, 1..15
) (
  input  logic i_clk,
  input  logic i_rst,
  flash_rd_ctrl_if.master bus
);

  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYC - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

  state_t      state_q, state_d;
  logic        grant_q, grant_d;   // granted port: 1 = CHR, 0 = PRG
  logic        ptr_q, ptr_d;       // round-robin pointer: 1 = CHR next
  logic [3:0]  cnt_q, cnt_d;
  logic [22:0] addr_q, addr_d;
  logic [7:0]  prg_q, prg_d;
  logic [7:0]  chr_q, chr_d;
  logic        prg_ack_q, prg_ack_d;
  logic        chr_ack_q, chr_ack_d;
  logic        pick_chr;
  logic        hit;

`ifdef FLASH_RDCACHE_EN
  logic        prg_vld_q, prg_vld_d;
  logic        chr_vld_q, chr_vld_d;
  logic [19:0] prg_tag_q, prg_tag_d;
  logic [19:0] chr_tag_q, chr_tag_d;
`endif

  // State and datapath registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= IDLE;
      grant_q   <= 1'b0;
      ptr_q     <= 1'b0;
      cnt_q     <= '0;
      addr_q    <= '0;
      prg_q     <= '0;
      chr_q     <= '0;
      prg_ack_q <= 1'b0;
      chr_ack_q <= 1'b0;
`ifdef FLASH_RDCACHE_EN
      prg_vld_q <= 1'b0;
      chr_vld_q <= 1'b0;
      prg_tag_q <= '0;
      chr_tag_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      prg_q     <= prg_d;
      chr_q     <= chr_d;
      prg_ack_q <= prg_ack_d;
      chr_ack_q <= chr_ack_d;
`ifdef FLASH_RDCACHE_EN
      prg_vld_q <= prg_vld_d;
      chr_vld_q <= chr_vld_d;
      prg_tag_q <= prg_tag_d;
      chr_tag_q <= chr_tag_d;
`endif
    end
  end

  // Next-state logic: arbitration, access countdown, handshake completion.
  // NOTE: every variable gets a hold/default value first so no path through
  // the case leaves one unassigned, which would infer a latch.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    prg_d     = prg_q;
    chr_d     = chr_q;
    prg_ack_d = prg_ack_q;
    chr_ack_d = chr_ack_q;
    pick_chr  = 1'b0;
    hit       = 1'b0;
`ifdef FLASH_RDCACHE_EN
    prg_vld_d = prg_vld_q;
    chr_vld_d = chr_vld_q;
    prg_tag_d = prg_tag_q;
    chr_tag_d = chr_tag_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (bus.i_prg_req || bus.i_chr_req) begin
          // CHR wins when it is alone, or when both ask and it is CHR's turn.
          pick_chr = bus.i_chr_req && (!bus.i_prg_req || ptr_q);
          // Pointer moves only on contention, to the port that lost.
          if (bus.i_prg_req && bus.i_chr_req) ptr_d = !ptr_q;
          grant_d = pick_chr;
`ifdef FLASH_RDCACHE_EN
          hit = pick_chr ? (chr_vld_q && (chr_tag_q == bus.i_chr_addr))
                         : (prg_vld_q && (prg_tag_q == bus.i_prg_addr));
`endif
          if (hit) begin
            // Cached byte is already in the port's q register.
            state_d = ACK;
            if (pick_chr) chr_ack_d = 1'b1;
            else          prg_ack_d = 1'b1;
          end else begin
            addr_d  = pick_chr ? {3'b100, bus.i_chr_addr} : {3'b000, bus.i_prg_addr};
            cnt_d   = CNT_LOAD;
            state_d = ACCESS;
          end
        end
      end

      ACCESS: begin
        if (cnt_q == 4'd0) begin
          if (grant_q) begin
            chr_d     = bus.i_flash_q;
            chr_ack_d = 1'b1;
`ifdef FLASH_RDCACHE_EN
            chr_vld_d = 1'b1;
            chr_tag_d = addr_q[19:0];
`endif
          end else begin
            prg_d     = bus.i_flash_q;
            prg_ack_d = 1'b1;
`ifdef FLASH_RDCACHE_EN
            prg_vld_d = 1'b1;
            prg_tag_d = addr_q[19:0];
`endif
          end
          state_d = ACK;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      ACK: begin
        // Hold ack until the granted requester lets go of req.
        if (!(grant_q ? bus.i_chr_req : bus.i_prg_req)) begin
          prg_ack_d = 1'b0;
          chr_ack_d = 1'b0;
          state_d   = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.o_prg_ack    = prg_ack_q;
  assign bus.o_prg_q      = prg_q;
  assign bus.o_chr_ack    = chr_ack_q;
  assign bus.o_chr_q      = chr_q;
  assign bus.o_flash_addr = addr_q;
  assign bus.o_flash_ce_n = (state_q != ACCESS);
  assign bus.o_flash_oe_n = (state_q != ACCESS);

endmodule
